// File: rtl/crc_frame_ctrl.sv
// Frame sequencer for the 8-bit serial CRC engine: seeds the engine, serializes
// byte-wide frames LSB-first, then gathers the serial CRC into one output word.
module crc_frame_ctrl #(
  parameter int unsigned DATA_WIDTH    = 8,
  parameter int unsigned CRC_WIDTH     = 8,
  parameter int unsigned DRAIN_TIMEOUT = 16
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] IN_DATA,
  input  logic                  IN_VALID,
  input  logic                  IN_LAST,
  output logic                  IN_READY,
  output logic                  CRC_RST,
  output logic                  CRC_DATA,
  output logic                  CRC_ACTIVE,
  input  logic                  CRC_BIT,
  input  logic                  CRC_VALID,
  output logic [CRC_WIDTH-1:0]  CRC_OUT,
  output logic                  CRC_DONE,
  output logic                  ERR,
  output logic                  BUSY
);

  localparam int unsigned BitCntW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam int unsigned RxCntW  = $clog2(CRC_WIDTH + 1);
  localparam int unsigned TmoCntW = $clog2(DRAIN_TIMEOUT + 1);

  localparam logic [BitCntW-1:0] BitLast = BitCntW'(DATA_WIDTH - 1);
  localparam logic [RxCntW-1:0]  RxFull  = RxCntW'(CRC_WIDTH);
  localparam logic [TmoCntW-1:0] TmoLast = TmoCntW'(DRAIN_TIMEOUT - 1);

  typedef enum logic [2:0] {
    StIdle,
    StSeed,
    StShift,
    StDrain,
    StDone
  } state_e;

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] sreg_q, sreg_d;
  logic                  last_q, last_d;
  logic [BitCntW-1:0]    bit_cnt_q, bit_cnt_d;
  logic [RxCntW-1:0]     rx_cnt_q, rx_cnt_d;
  logic [TmoCntW-1:0]    tmo_cnt_q, tmo_cnt_d;
  logic [CRC_WIDTH-1:0]  collect_q, collect_d;
  logic [CRC_WIDTH-1:0]  crc_out_q, crc_out_d;
  logic                  err_q, err_d;

  logic                  word_end;
  logic                  in_ready;
  logic [RxCntW-1:0]     rx_cnt_inc;
  logic [CRC_WIDTH-1:0]  collect_next;

  assign word_end     = (state_q == StShift) && (bit_cnt_q == BitLast);
  // Ready is a pure register decode, so the framer sees no input-to-output path.
  assign in_ready     = (state_q == StIdle) || (word_end && !last_q);
  assign rx_cnt_inc   = rx_cnt_q + RxCntW'(1);
  assign collect_next = collect_q | ({{(CRC_WIDTH-1){1'b0}}, CRC_BIT} << rx_cnt_q);

  always_comb begin
    state_d   = state_q;
    sreg_d    = sreg_q;
    last_d    = last_q;
    bit_cnt_d = bit_cnt_q;
    rx_cnt_d  = rx_cnt_q;
    tmo_cnt_d = tmo_cnt_q;
    collect_d = collect_q;
    crc_out_d = crc_out_q;
    err_d     = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (IN_VALID) begin
          sreg_d    = IN_DATA;
          last_d    = IN_LAST;
          bit_cnt_d = '0;
          state_d   = StSeed;
        end
      end

      StSeed: begin
        state_d = StShift;
      end

      StShift: begin
        bit_cnt_d = bit_cnt_q + BitCntW'(1);
        if (word_end) begin
          bit_cnt_d = '0;
          if (last_q) begin
            rx_cnt_d  = '0;
            tmo_cnt_d = '0;
            collect_d = '0;
            state_d   = StDrain;
          end else if (IN_VALID) begin
            sreg_d = IN_DATA;
            last_d = IN_LAST;
          end else begin
            // Underrun: abandon the frame; the next seed pulse clears the engine.
            err_d   = 1'b1;
            state_d = StIdle;
          end
        end
      end

      StDrain: begin
        tmo_cnt_d = tmo_cnt_q + TmoCntW'(1);
        if (CRC_VALID) begin
          collect_d = collect_next;
          rx_cnt_d  = rx_cnt_inc;
        end
        // A final bit landing on the last allowed cycle still counts as success.
        if (CRC_VALID && (rx_cnt_inc == RxFull)) begin
          crc_out_d = collect_next;
          state_d   = StDone;
        end else if (tmo_cnt_q == TmoLast) begin
          err_d   = 1'b1;
          state_d = StIdle;
        end
      end

      StDone: begin
        state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q   <= StIdle;
      sreg_q    <= '0;
      last_q    <= 1'b0;
      bit_cnt_q <= '0;
      rx_cnt_q  <= '0;
      tmo_cnt_q <= '0;
      collect_q <= '0;
      crc_out_q <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      sreg_q    <= sreg_d;
      last_q    <= last_d;
      bit_cnt_q <= bit_cnt_d;
      rx_cnt_q  <= rx_cnt_d;
      tmo_cnt_q <= tmo_cnt_d;
      collect_q <= collect_d;
      crc_out_q <= crc_out_d;
      err_q     <= err_d;
    end
  end

  assign IN_READY   = in_ready;
  assign CRC_RST    = (state_q != StSeed);
  assign CRC_ACTIVE = (state_q == StShift);
  assign CRC_DATA   = (state_q == StShift) && sreg_q[bit_cnt_q];
  assign CRC_OUT    = crc_out_q;
  assign CRC_DONE   = (state_q == StDone);
  assign ERR        = err_q;
  assign BUSY       = (state_q != StIdle);

endmodule

// File: tb/tb_crc_frame_ctrl.sv
// Directed bench for crc_frame_ctrl with a behavioural serial CRC engine stub
// that returns the fixed bit pattern 1,0,1,0,0,1,0,1 (8'hA5) after each frame.
module tb_crc_frame_ctrl;

  logic       CLK;
  logic       RST;
  logic [7:0] IN_DATA;
  logic       IN_VALID;
  logic       IN_LAST;
  logic       IN_READY;
  logic       CRC_RST;
  logic       CRC_DATA;
  logic       CRC_ACTIVE;
  logic       CRC_BIT;
  logic       CRC_VALID;
  logic [7:0] CRC_OUT;
  logic       CRC_DONE;
  logic       ERR;
  logic       BUSY;

  crc_frame_ctrl #(
    .DATA_WIDTH    (8),
    .CRC_WIDTH     (8),
    .DRAIN_TIMEOUT (16)
  ) u_dut (
    .CLK        (CLK),
    .RST        (RST),
    .IN_DATA    (IN_DATA),
    .IN_VALID   (IN_VALID),
    .IN_LAST    (IN_LAST),
    .IN_READY   (IN_READY),
    .CRC_RST    (CRC_RST),
    .CRC_DATA   (CRC_DATA),
    .CRC_ACTIVE (CRC_ACTIVE),
    .CRC_BIT    (CRC_BIT),
    .CRC_VALID  (CRC_VALID),
    .CRC_OUT    (CRC_OUT),
    .CRC_DONE   (CRC_DONE),
    .ERR        (ERR),
    .BUSY       (BUSY)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  // Stub modes: 0 = 8 back-to-back bits, 1 = 3-cycle gap after bit 4, 2 = silent.
  int         stub_mode = 0;
  logic [7:0] stub_bits = 8'hA5;

  initial begin
    logic act_prev;
    int   s_idx;
    int   s_gap;
    bit   running;
    act_prev  = 1'b0;
    running   = 1'b0;
    s_idx     = 0;
    s_gap     = 0;
    CRC_VALID = 1'b0;
    CRC_BIT   = 1'b0;
    forever begin
      @(negedge CLK);
      CRC_VALID = 1'b0;
      if (act_prev && !CRC_ACTIVE && stub_mode != 2) begin
        running = 1'b1;
        s_idx   = 0;
        s_gap   = 0;
      end
      if (running) begin
        if (stub_mode == 1 && s_idx == 5 && s_gap < 3) begin
          s_gap++;
        end else begin
          CRC_VALID = 1'b1;
          CRC_BIT   = stub_bits[s_idx];
          s_idx++;
          if (s_idx == 8) running = 1'b0;
        end
      end
      act_prev = CRC_ACTIVE;
    end
  end

  logic [7:0]  words [0:3];
  int          done_cyc, err_cyc, err_cnt, act_cnt, act_first, act_last, rst_low_cnt;
  logic        busy_at_err;
  logic [31:0] ready_mask;
  logic [31:0] data_vec;

  // Cycle c is the cycle after the c-th rising edge, counting the accept edge as 0.
  task automatic run_frame(input int n_words, input bit underrun, input int n_cyc);
    int idx;
    done_cyc    = -1;
    err_cyc     = -1;
    err_cnt     = 0;
    act_cnt     = 0;
    act_first   = -1;
    act_last    = -1;
    rst_low_cnt = 0;
    busy_at_err = 1'b1;
    ready_mask  = '0;
    data_vec    = '0;
    @(negedge CLK);
    IN_DATA  = words[0];
    IN_LAST  = (n_words == 1) && !underrun;
    IN_VALID = 1'b1;
    check_eq("idle_ready", {31'd0, IN_READY}, 32'd1);
    @(posedge CLK);
    #1;
    idx = 1;
    for (int c = 1; c <= n_cyc; c++) begin
      if (idx < n_words) begin
        IN_DATA = words[idx];
        IN_LAST = (idx == n_words - 1) && !underrun;
      end else begin
        IN_VALID = 1'b0;
        IN_LAST  = 1'b0;
      end
      @(negedge CLK);
      if (IN_READY && BUSY && c < 32) ready_mask[c] = 1'b1;
      if (CRC_ACTIVE) begin
        if (act_first < 0) act_first = c;
        act_last = c;
        if (act_cnt < 32) data_vec[act_cnt] = CRC_DATA;
        act_cnt++;
      end
      if (!CRC_RST) rst_low_cnt++;
      if (CRC_DONE && done_cyc < 0) done_cyc = c;
      if (ERR) begin
        err_cnt++;
        if (err_cyc < 0) begin
          err_cyc     = c;
          busy_at_err = BUSY;
        end
      end
      if (IN_VALID && IN_READY) begin
        @(posedge CLK);
        #1;
        idx++;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    RST      = 1'b0;
    IN_DATA  = '0;
    IN_VALID = 1'b0;
    IN_LAST  = 1'b0;
    #2;
    check_eq("reset_ctl", {25'd0, IN_READY, CRC_RST, CRC_DATA, CRC_ACTIVE, CRC_DONE, ERR, BUSY},
             32'b1100000);
    check_eq("reset_out", {24'd0, CRC_OUT}, 32'h0);
    repeat (2) @(negedge CLK);
    RST = 1'b1;

    // Single-word frame.
    words[0] = 8'h5A;
    run_frame(1, 1'b0, 30);
    check_eq("single_done_cyc", done_cyc, 18);
    check_eq("single_crc_out", {24'd0, CRC_OUT}, 32'hA5);
    check_eq("single_data_bits", data_vec, 32'h5A);
    check_eq("single_act_cnt", act_cnt, 8);
    check_eq("single_act_first", act_first, 2);
    check_eq("single_err_cnt", err_cnt, 0);
    check_eq("single_seed_cnt", rst_low_cnt, 1);
    check_eq("single_ready", ready_mask, 32'h0);

    // Back-to-back three-word frame with IN_VALID held.
    words[0] = 8'h01;
    words[1] = 8'h02;
    words[2] = 8'h03;
    run_frame(3, 1'b0, 45);
    check_eq("b2b_done_cyc", done_cyc, 34);
    check_eq("b2b_ready", ready_mask, (32'd1 << 9) | (32'd1 << 17));
    check_eq("b2b_act_cnt", act_cnt, 24);
    check_eq("b2b_act_span", act_last - act_first + 1, 24);
    check_eq("b2b_act_first", act_first, 2);
    check_eq("b2b_data_bits", data_vec, 32'h030201);
    check_eq("b2b_seed_cnt", rst_low_cnt, 1);
    check_eq("b2b_crc_out", {24'd0, CRC_OUT}, 32'hA5);
    check_eq("b2b_err_cnt", err_cnt, 0);

    // Underrun after a non-last word.
    words[0] = 8'hFF;
    run_frame(1, 1'b1, 30);
    check_eq("under_err_cyc", err_cyc, 10);
    check_eq("under_err_cnt", err_cnt, 1);
    check_eq("under_done", done_cyc, -1);
    check_eq("under_busy", {31'd0, busy_at_err}, 32'd0);
    check_eq("under_ready", ready_mask, 32'd1 << 9);
    words[0] = 8'h5A;
    run_frame(1, 1'b0, 30);
    check_eq("post_under_done", done_cyc, 18);
    check_eq("post_under_out", {24'd0, CRC_OUT}, 32'hA5);
    check_eq("post_under_err", err_cnt, 0);

    // Drain timeout: engine never asserts Valid.
    stub_mode = 2;
    run_frame(1, 1'b0, 35);
    check_eq("tmo_err_cyc", err_cyc, 26);
    check_eq("tmo_err_cnt", err_cnt, 1);
    check_eq("tmo_done", done_cyc, -1);
    check_eq("tmo_crc_out", {24'd0, CRC_OUT}, 32'hA5);

    // Valid gap during drain.
    stub_mode = 1;
    run_frame(1, 1'b0, 35);
    check_eq("gap_done_cyc", done_cyc, 21);
    check_eq("gap_crc_out", {24'd0, CRC_OUT}, 32'hA5);
    check_eq("gap_err_cnt", err_cnt, 0);
    stub_mode = 0;

    // Asynchronous reset during SHIFT of the second word.
    @(negedge CLK);
    IN_DATA  = 8'h11;
    IN_LAST  = 1'b0;
    IN_VALID = 1'b1;
    @(posedge CLK);
    #1;
    IN_DATA = 8'h22;
    IN_LAST = 1'b1;
    repeat (11) @(posedge CLK);
    #1;
    IN_VALID = 1'b0;
    IN_LAST  = 1'b0;
    check_eq("pre_rst_active", {30'd0, CRC_ACTIVE, BUSY}, 32'b11);
    #2;
    RST = 1'b0;
    #1;
    check_eq("mid_rst_ctl", {25'd0, IN_READY, CRC_RST, CRC_DATA, CRC_ACTIVE, CRC_DONE, ERR, BUSY},
             32'b1100000);
    check_eq("mid_rst_out", {24'd0, CRC_OUT}, 32'h0);
    @(negedge CLK);
    RST = 1'b1;
    repeat (12) @(negedge CLK);
    words[0] = 8'h5A;
    run_frame(1, 1'b0, 30);
    check_eq("post_rst_done", done_cyc, 18);
    check_eq("post_rst_out", {24'd0, CRC_OUT}, 32'hA5);
    check_eq("post_rst_bits", data_vec, 32'h5A);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/crc_frame_ctrl.md
Name: crc_frame_ctrl

Overview:
Frame sequencer for the team's 8-bit serial CRC engine (DATA/ACTIVE in, CRC/Valid out, seed loaded on its active-low RST).
- Accepts byte-wide frames over a valid/ready handshake.
- Re-seeds the engine at the start of every frame, then serializes each byte LSB-first into the engine.
- Collects the 8 serial CRC bits the engine emits after ACTIVE falls and presents them as one byte with a done pulse.
- Sits between the byte-oriented framer and the serial CRC engine. Flags underrun and drain timeout.

Parameters:
DATA_WIDTH, 8, bits per input word; serialized LSB-first.
CRC_WIDTH, 8, number of serial CRC bits collected after each frame.
DRAIN_TIMEOUT, 16, maximum DRAIN cycles allowed to collect CRC_WIDTH bits.

Ports:
CLK  input  1  module operating clock.
RST  input  1  asynchronous active-low reset. One clock; reset is asynchronous and active-low.
IN_DATA  input  DATA_WIDTH  frame word.
IN_VALID  input  1  IN_DATA/IN_LAST valid.
IN_LAST  input  1  marks final word of the frame.
IN_READY  output  1  controller accepts a word this cycle.
CRC_RST  output  1  active-low seed pulse to the engine RST.
CRC_DATA  output  1  serial bit to the engine DATA.
CRC_ACTIVE  output  1  to the engine ACTIVE.
CRC_BIT  input  1  engine serial CRC output.
CRC_VALID  input  1  engine Valid.
CRC_OUT  output  CRC_WIDTH  assembled CRC; bit i = i-th collected bit.
CRC_DONE  output  1  one-cycle pulse, CRC_OUT valid.
ERR  output  1  one-cycle pulse on underrun or drain timeout.
BUSY  output  1  high in every state except IDLE.

Behaviour:
- Reset values: state=IDLE, IN_READY=1, CRC_RST=1, CRC_DATA=0, CRC_ACTIVE=0, CRC_OUT=0, CRC_DONE=0, ERR=0, BUSY=0. All internal counters and the shift register are cleared.
- Moore outputs: all outputs decode from registers only. There is no combinational path from any input to any output.
- States: IDLE, SEED, SHIFT, DRAIN, DONE.
- IDLE: IN_READY=1. On IN_VALID&IN_READY, load the shift register with IN_DATA, latch IN_LAST, clear bit_cnt, go to SEED. CRC_BIT/CRC_VALID are ignored in IDLE.
- SEED: exactly 1 cycle. CRC_RST=0, CRC_ACTIVE=0, IN_READY=0. Then go to SHIFT.
- SHIFT: CRC_ACTIVE=1, CRC_DATA=sreg[bit_cnt], bit_cnt increments each cycle.
  - IN_READY=1 only when bit_cnt==DATA_WIDTH-1 and the latched last flag is 0.
  - At bit_cnt==DATA_WIDTH-1:
    - last=1: go to DRAIN.
    - last=0 and handshake: reload sreg and last, bit_cnt=0, stay in SHIFT. Back-to-back words produce no ACTIVE gap.
    - last=0 and no IN_VALID: underrun. ERR pulses next cycle, go to IDLE, CRC_DONE is not asserted. Engine residue is discarded; the next frame's SEED clears it.
- DRAIN: CRC_ACTIVE=0, IN_READY=0.
  - Each cycle with CRC_VALID=1, place CRC_BIT at position rx_cnt of a collection register and increment rx_cnt.
  - When rx_cnt reaches CRC_WIDTH, copy the register into CRC_OUT and go to DONE.
  - If DRAIN_TIMEOUT cycles elapse without CRC_WIDTH bits, ERR pulses, go to IDLE, CRC_OUT is unchanged.
- DONE: CRC_DONE=1 for 1 cycle, then go to IDLE. CRC_OUT holds until the next successful frame.
- Latency (engine asserts Valid 1 cycle after ACTIVE falls, for 8 cycles):
  - Accept edge at cycle 0; SHIFT covers cycles 2..8N+1.
  - CRC_DONE is high exactly 8N+10 cycles after the accepting edge for an N-word frame.
- Single-word frame: IN_LAST=1 on the first word gives SEED, 8 SHIFT cycles, DRAIN.
- CRC_VALID with a gap in DRAIN: bits are collected only on valid cycles; the timeout counter keeps running.
- Asynchronous reset mid-frame: everything returns to reset values immediately. CRC_RST returns to 1, so the engine is not seeded by the controller; the engine shares the system RST.

Test Plan:
- Single word 8'h5A, IN_LAST=1, engine stub returning bits 1,0,1,0,0,1,0,1 -> CRC_DATA sequence 0,1,0,1,1,0,1,0 under CRC_ACTIVE=1 for 8 cycles; CRC_OUT=8'hA5; CRC_DONE 18 cycles after accept; ERR=0.
- Back-to-back 3 words 8'h01,8'h02,8'h03 (last on 3rd) with IN_VALID held -> IN_READY high only on cycles 9 and 17 after accept; CRC_ACTIVE high 24 consecutive cycles; CRC_RST low exactly once; CRC_DONE at cycle 34.
- Underrun: word 8'hFF last=0, IN_VALID low at bit 7 -> ERR single pulse, state IDLE, CRC_DONE never asserted; next frame 8'h5A still yields 8'hA5 from the stub.
- Drain timeout: stub never asserts CRC_VALID -> ERR pulse 16 cycles after entering DRAIN, CRC_OUT keeps the previous 8'hA5.
- Stub with a 3-cycle CRC_VALID gap after bit 4 -> CRC_OUT still 8'hA5, CRC_DONE 3 cycles later than nominal, no ERR.
- RST asserted during SHIFT of word 2 -> all outputs at reset values within the same cycle; the next frame completes normally.
